// File: rtl/lm_sm_sequencer_pkg.sv
// Shared ISA definitions for the load-multiple / store-multiple sequencer:
// opcode values, register count and the sequencer state encoding.
package lm_sm_sequencer_pkg;

    // Number of architectural registers, which is also the width of the LM/SM mask.
    localparam int REG_N = 8;

    // Opcodes of the two multi-register memory instructions.
    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    // Sequencer states. These are plain constants so older code can use them too.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_DONE0 = 2'd2;

endpackage

// File: rtl/lm_sm_sequencer_lsb_pri_enc.sv
// Lowest-set-bit priority encoder. The hazard unit can reuse it.
// o_index is the position of the least significant set bit of i_vec.
// o_any shows whether any bit is set. When i_vec is zero, o_index is 0.
module lsb_pri_enc #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_index,
    output logic          o_any
);

    // Scan from the top bit down, so the lowest set bit is the last one written.
    always_comb begin
        o_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_index = IW'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer. It turns one load-multiple or store-multiple instruction
// into a series of single-register memory transfers.
// The lowest register goes first, at base, base+1, and so on.
// Fetch stays stalled until the instruction has finished.
// Handshake: start is a one-cycle valid. It is only accepted in IDLE and cannot be back-pressured.
// While busy, stall_fetch keeps the front end from presenting another start.
// hold is a downstream stall that freezes the sequencer and masks every strobe.
module lm_sm_sequencer #(
    parameter int         ADDR_W = 16,
    parameter int         REG_N  = lm_sm_sequencer_pkg::REG_N,
    parameter logic [3:0] OP_LM  = lm_sm_sequencer_pkg::OP_LM,
    parameter logic [3:0] OP_SM  = lm_sm_sequencer_pkg::OP_SM
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [REG_N-1:0]  imm_mask,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              hold,
    output logic              busy,
    output logic              stall_fetch,
    output logic [2:0]        reg_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              reg_write,
    output logic              done
);

    import lm_sm_sequencer_pkg::*;

    logic [1:0]        r_state;
    logic [REG_N-1:0]  r_mask;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_count;
    logic              r_is_load;

    logic [2:0]        w_idx;
    logic              w_any;
    logic [REG_N-1:0]  w_mask_next;
    logic              w_is_lmsm;
    logic              w_in_xfer;
    logic              w_fire;

    // The register to transfer now is the lowest bit still set in the mask.
    lsb_pri_enc #(
        .N  (REG_N),
        .IW (3)
    ) u_enc (
        .i_vec   (r_mask),
        .o_index (w_idx),
        .o_any   (w_any)
    );

    assign w_is_lmsm   = (opcode == OP_LM) || (opcode == OP_SM);
    // Clearing the lowest set bit gives the mask left after this transfer.
    assign w_mask_next = r_mask & (r_mask - REG_N'(1));
    assign w_in_xfer   = (r_state == ST_XFER);
    assign w_fire      = w_in_xfer && w_any && !hold;

    // State, mask, base and count. Capture happens only in IDLE. hold freezes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_mask    <= '0;
            r_base    <= '0;
            r_count   <= '0;
            r_is_load <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && w_is_lmsm) begin
                        if (|imm_mask) begin
                            r_mask    <= imm_mask;
                            r_base    <= base_addr;
                            r_count   <= '0;
                            r_is_load <= (opcode == OP_LM);
                            r_state   <= ST_XFER;
                        end else begin
                            r_state   <= ST_DONE0;
                        end
                    end
                end
                ST_XFER: begin
                    if (!hold) begin
                        r_mask  <= w_mask_next;
                        r_count <= r_count + ADDR_W'(1);
                        if (w_mask_next == '0) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DONE0: begin
                    if (!hold) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output decode. Select and address appear only during XFER; strobes only when not held.
    always_comb begin
        busy        = (r_state != ST_IDLE);
        stall_fetch = !reset && (busy || (start && w_is_lmsm));
        reg_sel     = w_in_xfer ? w_idx : 3'd0;
        mem_addr    = w_in_xfer ? (r_base + r_count) : '0;
        mem_rd      = w_fire && r_is_load;
        reg_write   = w_fire && r_is_load;
        mem_wr      = w_fire && !r_is_load;
        done        = (w_fire && (w_mask_next == '0)) ||
                      ((r_state == ST_DONE0) && !hold);
    end

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Multi-cycle controller that expands one load-multiple (LM) or store-multiple (SM) instruction into a series of single-register memory transfers.
- Sits at the execute/memory boundary, between the decoder and the register-file/data-memory datapath. It drives register-select, memory-address and write strobes.
- Holds fetch/decode stalled until the sequence completes.
- Writeback of LM data uses the normal reg_write path. Flag logic is not touched: LM/SM never update C or Z.

Parameters:
- ADDR_W, 16, data-memory address width.
- REG_N, 8, number of architectural registers; also the width of the register mask.
- OP_LM, 4'b0110, LM opcode value.
- OP_SM, 4'b0111, SM opcode value.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  instruction valid in this stage for one cycle.
- opcode  in  4  opcode of the instruction in the stage.
- imm_mask  in  REG_N  register mask; bit i set means register i is transferred.
- base_addr  in  ADDR_W  start address (value of Ra).
- hold  in  1  downstream stall; freezes the sequencer.
- busy  out  1  high while state is not IDLE.
- stall_fetch  out  1  holds PC and IF/ID stage.
- reg_sel  out  3  register index for the current transfer.
- mem_addr  out  ADDR_W  address for the current transfer.
- mem_rd  out  1  read strobe (LM transfer).
- mem_wr  out  1  write strobe (SM transfer).
- reg_write  out  1  register-file write enable (LM transfer).
- done  out  1  one-cycle pulse marking the end of the instruction.

Behaviour:
- States: IDLE, XFER, DONE0.
- Reset (asynchronous, any state):
  - State goes to IDLE; mask, address and count registers clear.
  - All outputs 0; reg_sel = 0, mem_addr = 0.
  - An in-flight sequence is abandoned with no further strobes.
- IDLE:
  - start=1 with opcode OP_LM or OP_SM and imm_mask!=0: latch mask, base_addr and is_load; go to XFER.
  - start=1 with OP_LM/OP_SM and imm_mask=0: go to DONE0.
  - start with any other opcode: ignored.
- stall_fetch = busy OR (start AND opcode is LM/SM) in IDLE. This is combinational, so fetch freezes in the same cycle the instruction arrives.
- XFER: one transfer per cycle, lowest set mask bit first.
  - reg_sel = index of the lowest set bit (priority encode of the mask register).
  - mem_addr = latched base + transfer count, modulo 2^ADDR_W. Wrap-around is permitted and silent.
  - LM transfer: mem_rd=1, reg_write=1. SM transfer: mem_wr=1.
  - Each cycle with hold=0: clear the selected bit and increment count.
  - done=1 in the cycle whose transfer empties the mask; the next state is IDLE.
- Latency:
  - The first transfer is in the cycle after start.
  - N = popcount(imm_mask) transfer cycles; done is coincident with the Nth transfer.
  - busy falls on the cycle after done.
- DONE0: done=1, no strobes, then IDLE. This gives a 1-cycle instruction.
- hold=1 (XFER or DONE0):
  - State, mask, count and reg_sel/mem_addr are frozen.
  - mem_rd, mem_wr, reg_write and done are forced to 0.
  - On release, the same transfer reissues.
- start while busy: ignored. The pipeline is stalled, so this is a decoder error; it is not queued.
- Simultaneous reset and start: reset wins.
- mask/base capture occurs only in IDLE. Input changes while busy have no effect.

Decomposition:
- Shared package (the existing ISA package): OP_LM/OP_SM opcode constants; the state enum {IDLE, XFER, DONE0}; REG_N.
- One sub-module, lsb_pri_enc: REG_N-bit lowest-set-bit encoder with outputs index[2:0] and any. It is reusable by the hazard unit.

Test Plan:
- LM, imm_mask=8'b1000_0101, base=16'h0040:
  - Cycle 1: reg_sel 0 @ 0x0040. Cycle 2: reg_sel 2 @ 0x0041. Cycle 3: reg_sel 7 @ 0x0042.
  - mem_rd=reg_write=1 in all three cycles; done in cycle 3; busy low in cycle 4.
- SM, imm_mask=8'hFF, base=16'hFFFE:
  - 8 cycles, mem_wr=1 each cycle, reg_sel 0..7.
  - Addresses FFFE, FFFF, 0000…0005 (wrap); mem_rd=reg_write=0 throughout.
- LM, imm_mask=0 -> one cycle with done=1, busy=1; no strobes; IDLE next cycle.
- LM, mask=8'b0000_0110, hold=1 in the first XFER cycle for 2 cycles:
  - reg_sel=1/addr=base held with strobes low.
  - Transfers r1 then r2 after release; done on r2.
- Reset asserted mid-SM after 2 of 5 transfers -> asynchronous clear; outputs 0 immediately; later start behaves from IDLE.
- start with opcode 4'b0000 (ADD) -> no busy, no stall_fetch, no strobes.
- start during busy with a different mask -> ignored; the original sequence completes unchanged.
